// File: rtl/hwextra_ctrl_pkg.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | Module      : hwextra_ctrl_pkg                                         |
// | Description : Shared state encoding and default parameter values for   |
// |               the hwextra job sequencer.                               |
// | Revision    : 1.0 - initial release                                    |
// +-----------------------------------------------------------------------+
package hwextra_ctrl_pkg;

    // Sequencer states; the encoding is fixed at two bits.
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_FLUSH = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    localparam int c_def_width     = 32;
    localparam int c_def_cnt_w     = 8;
    localparam int c_def_depth     = 16;
    localparam int c_def_flush_cyc = 2;
    localparam int c_def_timeout   = 255;

endpackage : hwextra_ctrl_pkg
`default_nettype wire

// File: rtl/hwextra_ctrl_wdog.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | Module      : hwextra_ctrl_wdog                                        |
// | Description : Stall counter. Counts cycles with i_inc set, returns to  |
// |               zero on i_clr and saturates at TIMEOUT, where o_expire   |
// |               is raised.                                               |
// | Revision    : 1.0 - initial release                                    |
// +-----------------------------------------------------------------------+
module hwextra_ctrl_wdog
    import hwextra_ctrl_pkg::*;
#(
    parameter int TIMEOUT = c_def_timeout
) (
    input  logic clk,
    input  logic rst,
    input  logic i_clr,
    input  logic i_inc,
    output logic o_expire
);

    localparam int c_cnt_w = $clog2(TIMEOUT + 1);
    localparam logic [c_cnt_w-1:0] c_limit = c_cnt_w'(TIMEOUT);

    logic [c_cnt_w-1:0] r_cnt;

    // Stall count: clear wins over increment, holds once the limit is hit.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (i_clr) begin
            r_cnt <= '0;
        end else if (i_inc && (r_cnt != c_limit)) begin
            r_cnt <= r_cnt + c_cnt_w'(1);
        end
    end

    assign o_expire = (r_cnt == c_limit);

endmodule : hwextra_ctrl_wdog
`default_nettype wire

// File: rtl/hwextra_ctrl.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | Module      : hwextra_ctrl                                             |
// | Description : Job sequencer for the hwextra FIFO/sort/add datapath.    |
// |               Accepts a job of len words, runs FIFO pushes and pops    |
// |               concurrently, waits FLUSH_CYC cycles for the sort/add    |
// |               pipeline and pulses done.                                |
// |               Optional stall watchdog: HWEXTRA_CTRL_TIMEOUT_EN         |
// | Revision    : 1.0 - initial release                                    |
// +-----------------------------------------------------------------------+
module hwextra_ctrl
    import hwextra_ctrl_pkg::*;
#(
    parameter int WIDTH     = c_def_width,
    parameter int CNT_W     = c_def_cnt_w,
    parameter int DEPTH     = c_def_depth,
    parameter int FLUSH_CYC = c_def_flush_cyc,
    parameter int TIMEOUT   = c_def_timeout
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [CNT_W-1:0] len,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             hold,
    input  logic             FIFO_empty,
    output logic             FIFO_w_en,
    output logic             FIFO_en,
    output logic             sort_en,
    output logic             add_en,
    output logic             busy,
    output logic             done,
    output logic             err,
    output logic [CNT_W-1:0] pushed,
    output logic [CNT_W-1:0] popped
);

    // Reject configurations the sequencer cannot honour at elaboration time.
    generate
        if (WIDTH < 1 || DEPTH < 1 || FLUSH_CYC < 1 || TIMEOUT < 1) begin : g_param_check
            $error("hwextra_ctrl: WIDTH, DEPTH, FLUSH_CYC and TIMEOUT must all be >= 1");
        end
    endgenerate

    // Occupancy is one bit wider than the counters so DEPTH == 2**CNT_W still compares.
    localparam int                 c_occ_w      = CNT_W + 1;
    localparam logic [CNT_W:0]     c_depth      = c_occ_w'(DEPTH);
    localparam logic [CNT_W-1:0]   c_flush_last = CNT_W'(FLUSH_CYC - 1);

    state_t           r_state;
    logic [CNT_W-1:0] r_len;
    logic [CNT_W-1:0] r_pushed;
    logic [CNT_W-1:0] r_popped;
    logic [CNT_W-1:0] r_flush_cnt;
    logic             r_busy;
    logic             r_done;
    logic             r_err;

    logic             w_run;
    logic [CNT_W:0]   w_occ;
    logic             w_in_ready;
    logic             w_push;
    logic             w_pop;
    logic             w_last_pop;
    logic             w_expire;

    // Handshake and pop qualification, all decoded from registered counters.
    assign w_run      = (r_state == ST_RUN);
    assign w_occ      = {1'b0, r_pushed} - {1'b0, r_popped};
    assign w_in_ready = w_run && (r_pushed < r_len) && (w_occ < c_depth);
    assign w_push     = in_valid && w_in_ready;
    assign w_pop      = w_run && !hold && (w_occ != '0) && !FIFO_empty && (r_popped < r_len);
    assign w_last_pop = w_pop && (r_popped == (r_len - 1'b1));

`ifdef HWEXTRA_CTRL_TIMEOUT_EN
    // A RUN cycle counts as a stall only when nothing moves and hold is low.
    hwextra_ctrl_wdog #(
        .TIMEOUT (TIMEOUT)
    ) u_wdog (
        .clk      (clk),
        .rst      (reset),
        .i_clr    (!w_run || w_push || w_pop || hold),
        .i_inc    (w_run && !w_push && !w_pop && !hold),
        .o_expire (w_expire)
    );
`else
    assign w_expire = 1'b0;
`endif

    // Job sequencing FSM with registered busy/done/err and word counters.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= ST_IDLE;
            r_len       <= '0;
            r_pushed    <= '0;
            r_popped    <= '0;
            r_flush_cnt <= '0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_err       <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        r_len       <= len;
                        r_pushed    <= '0;
                        r_popped    <= '0;
                        r_flush_cnt <= '0;
                        r_err       <= 1'b0;
                        if (len != '0) begin
                            r_state <= ST_RUN;
                            r_busy  <= 1'b1;
                        end else begin
                            r_state <= ST_DONE;
                            r_done  <= 1'b1;
                        end
                    end
                end
                ST_RUN: begin
                    if (w_push) begin
                        r_pushed <= r_pushed + 1'b1;
                    end
                    if (w_pop) begin
                        r_popped <= r_popped + 1'b1;
                    end
                    if (w_last_pop) begin
                        r_state     <= ST_FLUSH;
                        r_flush_cnt <= '0;
                    end else if (w_expire) begin
                        r_state <= ST_DONE;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                        r_err   <= 1'b1;
                    end
                end
                ST_FLUSH: begin
                    if (r_flush_cnt == c_flush_last) begin
                        r_state <= ST_DONE;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                    end else begin
                        r_flush_cnt <= r_flush_cnt + 1'b1;
                    end
                end
                ST_DONE: begin
                    r_state <= ST_IDLE;
                    r_done  <= 1'b0;
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_busy  <= 1'b0;
                    r_done  <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready  = w_in_ready;
    assign FIFO_w_en = w_push;
    assign FIFO_en   = w_pop;
    assign busy      = r_busy;
    assign sort_en   = r_busy;
    assign add_en    = r_busy;
    assign done      = r_done;
    assign err       = r_err;
    assign pushed    = r_pushed;
    assign popped    = r_popped;

endmodule : hwextra_ctrl
`default_nettype wire

// File: tb/tb_hwextra_ctrl.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | Module      : tb_hwextra_ctrl                                          |
// | Description : Directed self-checking bench for hwextra_ctrl with a     |
// |               behavioural FIFO occupancy model driving FIFO_empty.     |
// | Revision    : 1.0 - initial release                                    |
// +-----------------------------------------------------------------------+
module tb_hwextra_ctrl;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       start = 1'b0;
    logic [7:0] len = '0;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic       hold = 1'b0;
    logic       FIFO_empty;
    logic       FIFO_w_en;
    logic       FIFO_en;
    logic       sort_en;
    logic       add_en;
    logic       busy;
    logic       done;
    logic       err;
    logic [7:0] pushed;
    logic [7:0] popped;

    int n_tests = 0;
    int n_fail  = 0;
    int fifo_cnt;

    // Per-cycle trace {FIFO_w_en, FIFO_en, sort_en, add_en, busy, done}
    logic [5:0] tr [0:255];

    int res_done, res_busy, res_en, res_first_pop, res_last_pop;
    int res_hold_pops, res_full_ready, res_max_occ, res_err, res_done_after;

    hwextra_ctrl #(
        .WIDTH     (32),
        .CNT_W     (8),
        .DEPTH     (16),
        .FLUSH_CYC (2),
        .TIMEOUT   (10)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .len        (len),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .hold       (hold),
        .FIFO_empty (FIFO_empty),
        .FIFO_w_en  (FIFO_w_en),
        .FIFO_en    (FIFO_en),
        .sort_en    (sort_en),
        .add_en     (add_en),
        .busy       (busy),
        .done       (done),
        .err        (err),
        .pushed     (pushed),
        .popped     (popped)
    );

    always #5 clk = ~clk;

    // Datapath FIFO occupancy model
    always @(posedge clk) begin
        if (reset) fifo_cnt <= 0;
        else       fifo_cnt <= fifo_cnt + (FIFO_w_en ? 1 : 0) - (FIFO_en ? 1 : 0);
    end
    assign FIFO_empty = (fifo_cnt == 0);

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, obs, obs, exp, exp);
        end
    endtask

    // Entered and left at a sample point (posedge + 3).
    task automatic do_reset();
        reset    = 1'b1;
        start    = 1'b0;
        in_valid = 1'b0;
        hold     = 1'b0;
        repeat (2) @(posedge clk);
        #3;
    endtask

    // Cycle 0 is the cycle where start is presented; cycles are sampled at posedge + 3.
    task automatic run_job(input int n, input int hold_until, input int valid_words,
                           input int restart_at, input int max_cyc);
        int pushes;
        pushes         = 0;
        res_done       = -1;
        res_busy       = 0;
        res_en         = 0;
        res_first_pop  = -1;
        res_last_pop   = -1;
        res_hold_pops  = 0;
        res_full_ready = 0;
        res_max_occ    = 0;
        res_err        = -1;
        res_done_after = -1;
        for (int i = 0; i < 256; i++) tr[i] = '0;
        start    = 1'b1;
        len      = 8'(n);
        hold     = (hold_until > 0);
        in_valid = (valid_words > 0);
        for (int c = 1; c <= max_cyc; c++) begin
            @(posedge clk);
            #1;
            start    = (c == restart_at);
            len      = (c == restart_at) ? 8'd99 : 8'(n);
            hold     = (c < hold_until);
            in_valid = (pushes < valid_words);
            #2;
            if (c < 256) tr[c] = {FIFO_w_en, FIFO_en, sort_en, add_en, busy, done};
            if (fifo_cnt > res_max_occ) res_max_occ = fifo_cnt;
            if (fifo_cnt == 16 && in_ready) res_full_ready++;
            if (FIFO_w_en) pushes++;
            if (FIFO_en) begin
                if (res_first_pop < 0) res_first_pop = c;
                res_last_pop = c;
                if (hold) res_hold_pops++;
            end
            if (busy) res_busy++;
            if (FIFO_w_en || FIFO_en || sort_en || add_en) res_en++;
            if (done) begin
                res_done = c;
                res_err  = int'(err);
                break;
            end
        end
        start    = 1'b0;
        in_valid = 1'b0;
        hold     = 1'b0;
        if (res_done > 0) begin
            @(posedge clk);
            #3;
            res_done_after = int'(done);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL global_time_limit: got timeout expected completion");
        $fatal(1, "simulation time limit");
    end

    initial begin
        // Reset state
        do_reset();
        check("reset_outputs", {in_ready, FIFO_w_en, FIFO_en, sort_en, add_en, busy, done, err}, 8'h00);
        check("reset_counts", {pushed, popped}, 16'h0000);
        reset = 1'b0;
        @(posedge clk);
        #3;

        // len=1, continuous source
        run_job(1, 0, 1, -1, 50);
        check("len1_c1", tr[1], 6'b101110);
        check("len1_c2", tr[2], 6'b011110);
        check("len1_c3", tr[3], 6'b001110);
        check("len1_c4", tr[4], 6'b001110);
        check("len1_c5", tr[5], 6'b000001);
        check("len1_done_cyc", res_done, 5);
        check("len1_done_pulse", res_done_after, 0);

        // len=4, continuous source
        run_job(4, 0, 4, -1, 50);
        check("len4_c1", tr[1], 6'b101110);
        check("len4_c3", tr[3], 6'b111110);
        check("len4_c5", tr[5], 6'b011110);
        check("len4_c7", tr[7], 6'b001110);
        check("len4_done_cyc", res_done, 8);
        check("len4_busy_cycles", res_busy, 7);
        check("len4_counts", {pushed, popped}, {8'd4, 8'd4});

        // len=4 with a start pulse during RUN that must be ignored
        run_job(4, 0, 4, 3, 50);
        check("restart_done_cyc", res_done, 8);
        check("restart_counts", {pushed, popped}, {8'd4, 8'd4});

        // len=20 with hold for cycles 1..19: FIFO fills to DEPTH, then drains
        run_job(20, 20, 20, -1, 200);
        check("hold_max_occ", res_max_occ, 16);
        check("hold_ready_when_full", res_full_ready, 0);
        check("hold_pops_during_hold", res_hold_pops, 0);
        check("hold_first_pop", res_first_pop, 20);
        check("hold_last_pop", res_last_pop, 39);
        check("hold_done_cyc", res_done, 42);
        check("hold_counts", {pushed, popped}, {8'd20, 8'd20});

        // len=0: immediate done, nothing enabled
        run_job(0, 0, 0, -1, 20);
        check("len0_done_cyc", res_done, 1);
        check("len0_busy_cycles", res_busy, 0);
        check("len0_enables", res_en, 0);
        check("len0_counts", {pushed, popped}, 16'h0000);

        // Reset in the middle of a job once three words are in
        start    = 1'b1;
        len      = 8'd8;
        in_valid = 1'b1;
        for (int c = 1; c <= 4; c++) begin
            @(posedge clk);
            #1;
            start = 1'b0;
            #2;
        end
        check("midrst_pushed_before", pushed, 8'd3);
        reset = 1'b1;
        @(posedge clk);
        #3;
        check("midrst_outputs", {in_ready, FIFO_w_en, FIFO_en, sort_en, add_en, busy, done, err}, 8'h00);
        check("midrst_counts", {pushed, popped}, 16'h0000);
        reset    = 1'b0;
        in_valid = 1'b0;
        begin
            int dones;
            dones = 0;
            for (int c = 0; c < 4; c++) begin
                @(posedge clk);
                #3;
                if (done || busy) dones++;
            end
            check("midrst_no_done", dones, 0);
        end
        run_job(4, 0, 4, -1, 50);
        check("after_rst_done_cyc", res_done, 8);
        check("after_rst_counts", {pushed, popped}, {8'd4, 8'd4});

        // Source stops after 2 of 5 words
        run_job(5, 0, 2, -1, 40);
`ifdef HWEXTRA_CTRL_TIMEOUT_EN
        check("stall_done_cyc", res_done, 15);
        check("stall_err_at_done", res_err, 1);
        check("stall_err_sticky", err, 1'b1);
        check("stall_counts", {pushed, popped}, {8'd2, 8'd2});
`else
        check("stall_no_done", res_done, -1);
        check("stall_busy", {busy, err}, 2'b10);
        check("stall_counts", {pushed, popped}, {8'd2, 8'd2});
        do_reset();
        reset = 1'b0;
        @(posedge clk);
        #3;
`endif
        // A fresh accepted start clears err
        run_job(0, 0, 0, -1, 20);
        check("err_cleared_by_start", res_err, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule : tb_hwextra_ctrl
`default_nettype wire

// File: doc/hwextra_ctrl.md
# hwextra_ctrl

Job sequencer for the hwextra FIFO/sort/add datapath. It accepts a job of `len` words from a valid/ready source and drives the datapath enables: FIFO write, FIFO pop, sort and add. It runs pushes and pops concurrently, waits for the sort/add pipeline to flush, then signals completion. It sits between the input source and the hwextra datapath and replaces hand-driven enable sequencing.

## Interface
- `WIDTH`, 32, datapath word width (pass-through context only; no data ports here)
- `CNT_W`, 8, width of job length and word counters
- `DEPTH`, 16, datapath FIFO depth, used for internal occupancy limit
- `FLUSH_CYC`, 2, cycles sort/add need after last pop, ≥1
- `TIMEOUT`, 255, stall limit in cycles (used only with macro)

Ports:
- `clk`  in  1  single clock, rising edge
- `reset`  in  1  synchronous, active-high
- `start`  in  1  job request, sampled only in IDLE
- `len`  in  CNT_W  word count of job, latched when start accepted
- `in_valid`  in  1  source has a word on datapath `data`
- `in_ready`  out  1  controller accepts word this cycle
- `hold`  in  1  suspend popping (pushes continue)
- `FIFO_empty`  in  1  datapath FIFO empty flag
- `FIFO_w_en`  out  1  datapath FIFO write enable
- `FIFO_en`  out  1  datapath FIFO pop enable
- `sort_en`  out  1  datapath sort enable
- `add_en`  out  1  datapath add enable
- `busy`  out  1  job in progress (RUN or FLUSH)
- `done`  out  1  one-cycle completion pulse
- `err`  out  1  stall timeout flag
- `pushed`  out  CNT_W  words written this job
- `popped`  out  CNT_W  words popped this job

## Operation
- States: IDLE, RUN, FLUSH, DONE.
- IDLE: start=1 and len≠0 → RUN, clear counters, latch len. start=1 and len=0 → DONE directly.
- RUN: `in_ready` = (pushed<len) & (occ<DEPTH), where occ = pushed−popped. `FIFO_w_en` = in_valid & in_ready, combinational. `FIFO_en` = !hold & (occ>0) & !FIFO_empty & (popped<len).
- RUN → FLUSH on the edge of the pop that makes popped==len.
- FLUSH: count FLUSH_CYC cycles, then → DONE. hold has no effect.
- DONE: done=1 for one cycle, then → IDLE. Counters keep final values until next accepted start.
- `sort_en` = `add_en` = `busy`. `in_ready`, `FIFO_w_en` and `FIFO_en` are 0 outside RUN.
- Push and pop in the same cycle: occ unchanged. A push is blocked when occ==DEPTH even if a pop occurs the same cycle.
- start outside IDLE is ignored.
- Counters never exceed len. No wrap-around within a job.
- Reset: state IDLE. All outputs 0 (`in_ready`, `FIFO_w_en`, `FIFO_en`, `sort_en`, `add_en`, `busy`, `done`, `err`), pushed=popped=0, FLUSH counter 0. Reset mid-job abandons the job with no done pulse.

## Timing
- Cycle 0 start sampled. Cycle 1 RUN, busy=1, first push possible.
- First pop at earliest cycle 2 (occ is registered).
- Continuous stream of len=N: pushes cycles 1..N, pops 2..N+1, FLUSH N+2..N+1+FLUSH_CYC, done at N+2+FLUSH_CYC, IDLE next cycle.
- Each hold cycle delays completion by one cycle.
- len=0: done at cycle 1, busy never asserted.

## Configuration
- `HWEXTRA_CTRL_TIMEOUT_EN` defined:
  - A stall counter increments each RUN cycle with no push, no pop and hold=0. It clears on any push or pop, or while hold=1.
  - When the counter reaches TIMEOUT: err=1, → DONE (done pulses).
  - err is sticky until the next accepted start or reset.
- Not defined: no counter, err tied 0, RUN waits indefinitely.

## Structure
- Package `hwextra_ctrl_pkg`: state typedef (2-bit enum IDLE/RUN/FLUSH/DONE) and default parameter constants.
- One sub-module, `hwextra_ctrl_wdog`: stall counter with clear/inc inputs and expire output, instantiated only under the macro.

## Test plan
- Reset, then start, len=1, in_valid held 1 → FIFO_w_en cycle 1, FIFO_en cycle 2, done cycle 5, busy cycles 1–4.
- len=4 with continuous in_valid, hold=0 → pushed=popped=4, done at cycle 8, sort_en/add_en high cycles 1–7.
- len=20, DEPTH=16, hold=1 for the first 20 cycles → in_ready drops when occ=16, FIFO_en=0 during hold. After hold releases, all 20 words pop and done follows FLUSH_CYC cycles after the last pop.
- start with len=0 → done at cycle 1, no enables asserted. start pulsed during RUN → ignored, counters unaffected.
- Reset asserted mid-RUN at pushed=3 → next cycle all outputs 0, state IDLE, no done. A fresh job then completes normally.
- With macro, TIMEOUT=10: in_valid=0 after 2 of 5 words, occ drains → err=1 and done once the counter reaches 10. Without macro: same stimulus keeps busy=1, err=0.
